// File: rtl/ethernet_transmitter_if.sv
// Host packet-fill port and AXIS TX stream of the Ethernet transmitter.
// Signal suffixes are from the transmitter's point of view.
interface ethernet_transmitter_if #(
    parameter int unsigned data_width_p = 64,
    parameter int unsigned eth_mtu_p    = 2048,
    parameter int unsigned send_count_p = 65535
);
    localparam int unsigned addr_width_lp        = $clog2(eth_mtu_p);
    localparam int unsigned size_width_lp        = $clog2($clog2(data_width_p / 8) + 1);
    localparam int unsigned packet_size_width_lp = $clog2(eth_mtu_p + 1);
    localparam int unsigned count_width_lp       = $clog2(send_count_p + 1);

    logic                            packet_req_o;
    logic                            packet_wvalid_i;
    logic [addr_width_lp-1:0]        packet_waddr_i;
    logic [data_width_p-1:0]         packet_wdata_i;
    logic [size_width_lp-1:0]        packet_wdata_size_i;
    logic                            packet_wsize_valid_i;
    logic [packet_size_width_lp-1:0] packet_wsize_i;
    logic                            packet_send_i;
    logic [data_width_p-1:0]         tx_axis_tdata_o;
    logic [data_width_p/8-1:0]       tx_axis_tkeep_o;
    logic                            tx_axis_tvalid_o;
    logic                            tx_axis_tready_i;
    logic                            tx_axis_tlast_o;
    logic                            tx_axis_tuser_o;
    logic [count_width_lp-1:0]       send_count_o;

    // Host and AXIS sink side
    modport master (
        input  packet_req_o,
        output packet_wvalid_i, packet_waddr_i, packet_wdata_i, packet_wdata_size_i,
        output packet_wsize_valid_i, packet_wsize_i, packet_send_i,
        input  tx_axis_tdata_o, tx_axis_tkeep_o, tx_axis_tvalid_o, tx_axis_tlast_o,
        input  tx_axis_tuser_o,
        output tx_axis_tready_i,
        input  send_count_o
    );

    // Transmitter side
    modport slave (
        output packet_req_o,
        input  packet_wvalid_i, packet_waddr_i, packet_wdata_i, packet_wdata_size_i,
        input  packet_wsize_valid_i, packet_wsize_i, packet_send_i,
        output tx_axis_tdata_o, tx_axis_tkeep_o, tx_axis_tvalid_o, tx_axis_tlast_o,
        output tx_axis_tuser_o,
        input  tx_axis_tready_i,
        output send_count_o
    );
endinterface

// File: rtl/ethernet_transmitter.sv
// Ping-pong packet buffer feeding an AXIS TX stream. The host fills one slot
// while the other is streamed; committed frames go out in commit order.
module ethernet_transmitter #(
    parameter int unsigned data_width_p = 64,
    parameter int unsigned eth_mtu_p    = 2048,
    parameter int unsigned send_count_p = 65535
) (
    input  logic                 clk_i,
    input  logic                 reset_n_i,
    ethernet_transmitter_if.slave bus
);
    localparam int unsigned bytes_lp             = data_width_p / 8;
    localparam int unsigned lsb_lp               = $clog2(bytes_lp);
    localparam int unsigned addr_width_lp        = $clog2(eth_mtu_p);
    localparam int unsigned packet_size_width_lp = $clog2(eth_mtu_p + 1);
    localparam int unsigned count_width_lp       = $clog2(send_count_p + 1);
    localparam int unsigned word_width_lp        = addr_width_lp - lsb_lp;
    localparam int unsigned words_lp             = eth_mtu_p / bytes_lp;

    typedef enum logic [1:0] {SlotEmpty, SlotReady, SlotSending} slot_state_e;
    typedef enum logic [1:0] {StIdle, StFetch, StStream} tx_state_e;

    // Slot memory: word index is {slot, word-in-slot}
    logic [data_width_p-1:0]         mem_q [2*words_lp];
    slot_state_e                     slot_q [2];
    slot_state_e                     slot_d [2];
    logic [packet_size_width_lp-1:0] size_q [2];
    logic                            wr_ptr_q, rd_ptr_q, req_en_q;
    tx_state_e                       state_q, state_d;
    logic [word_width_lp-1:0]        beat_q;
    logic [data_width_p-1:0]         tdata_q;
    logic [bytes_lp-1:0]             tkeep_q;
    logic                            tvalid_q, tlast_q;
    logic [count_width_lp-1:0]       count_q;

    logic                            packet_req, wr_legal, wr_en, commit;
    logic [lsb_lp-1:0]               wr_off;
    logic [word_width_lp-1:0]        wr_word;
    logic [bytes_lp-1:0]             wr_be;
    logic [data_width_p-1:0]         wr_data;
    logic [packet_size_width_lp-1:0] wsize_clamped, commit_size;

    logic [packet_size_width_lp-1:0] rd_size, rd_beats;
    logic [lsb_lp-1:0]               rd_rem;
    logic                            handshake, last_hs;
    logic                            load, load_last;
    logic [word_width_lp-1:0]        load_word;
    logic [bytes_lp-1:0]             load_keep;

    assign packet_req  = req_en_q && (slot_q[wr_ptr_q] == SlotEmpty);
    assign wr_off      = bus.packet_waddr_i[lsb_lp-1:0];
    assign wr_word     = bus.packet_waddr_i[addr_width_lp-1:lsb_lp];
    assign wr_en       = packet_req && bus.packet_wvalid_i && wr_legal;

    // Decode write size into byte lanes; writes must be naturally aligned
    always_comb begin
        int unsigned nbytes;
        nbytes   = 32'd1 << bus.packet_wdata_size_i;
        wr_legal = (32'(bus.packet_wdata_size_i) <= lsb_lp) &&
                   ((32'(wr_off) & (nbytes - 32'd1)) == 32'd0);
        for (int b = 0; b < int'(bytes_lp); b++) begin
            wr_be[b] = (b >= int'(wr_off)) && (b < int'(wr_off) + int'(nbytes));
        end
        wr_data = bus.packet_wdata_i << {wr_off, 3'b000};
    end

    // Size latch with same-cycle bypass into the commit
    always_comb begin
        wsize_clamped = (bus.packet_wsize_i > packet_size_width_lp'(eth_mtu_p)) ?
                        packet_size_width_lp'(eth_mtu_p) : bus.packet_wsize_i;
        commit_size   = bus.packet_wsize_valid_i ? wsize_clamped : size_q[wr_ptr_q];
        commit        = packet_req && bus.packet_send_i && (commit_size != '0);
    end

    assign rd_size   = size_q[rd_ptr_q];
    assign rd_beats  = (rd_size + packet_size_width_lp'(bytes_lp - 1)) >> lsb_lp;
    assign rd_rem    = rd_size[lsb_lp-1:0];
    assign handshake = tvalid_q && bus.tx_axis_tready_i;
    assign last_hs   = handshake && tlast_q;

    // TX FSM state register
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) state_q <= StIdle;
        else            state_q <= state_d;
    end

    // TX FSM next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (slot_q[rd_ptr_q] == SlotReady) state_d = StFetch;
            StFetch:  if (last_hs) state_d = StIdle; else if (handshake) state_d = StStream;
            StStream: if (last_hs) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // TX FSM outputs: when to load the next word into the output register
    always_comb begin
        load      = 1'b0;
        load_word = '0;
        unique case (state_q)
            StIdle: load = (slot_q[rd_ptr_q] == SlotReady);
            StFetch, StStream: begin
                load      = handshake && !tlast_q;
                load_word = beat_q + 1'b1;
            end
            default: load = 1'b0;
        endcase
        load_last = (packet_size_width_lp'(load_word) + packet_size_width_lp'(1)) == rd_beats;
        for (int b = 0; b < int'(bytes_lp); b++) begin
            load_keep[b] = !(load_last && (rd_rem != '0)) || (b < int'(rd_rem));
        end
    end

    // Slot state transitions; commit and last handshake always target different slots
    always_comb begin
        slot_d[0] = slot_q[0];
        slot_d[1] = slot_q[1];
        if (commit)                  slot_d[wr_ptr_q] = SlotReady;
        if (state_q == StIdle && load) slot_d[rd_ptr_q] = SlotSending;
        if (last_hs)                 slot_d[rd_ptr_q] = SlotEmpty;
    end

    // Slot bookkeeping, pointers and frame counter
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            slot_q[0] <= SlotEmpty;
            slot_q[1] <= SlotEmpty;
            size_q[0] <= '0;
            size_q[1] <= '0;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            req_en_q  <= 1'b0;
            count_q   <= '0;
        end else begin
            slot_q[0] <= slot_d[0];
            slot_q[1] <= slot_d[1];
            req_en_q  <= 1'b1;
            if (packet_req && bus.packet_wsize_valid_i) size_q[wr_ptr_q] <= wsize_clamped;
            if (commit) wr_ptr_q <= ~wr_ptr_q;
            if (last_hs) begin
                rd_ptr_q <= ~rd_ptr_q;
                count_q  <= (count_q == count_width_lp'(send_count_p)) ? '0 : count_q + 1'b1;
            end
        end
    end

    // Output register doubles as the memory read port; holds until handshake
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            tdata_q  <= '0;
            tkeep_q  <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            beat_q   <= '0;
        end else if (load) begin
            tdata_q  <= mem_q[{rd_ptr_q, load_word}];
            tkeep_q  <= load_keep;
            tvalid_q <= 1'b1;
            tlast_q  <= load_last;
            beat_q   <= load_word;
        end else if (last_hs) begin
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
        end
    end

    // Byte-enable write into the slot being filled
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            for (int b = 0; b < int'(bytes_lp); b++) begin
                if (wr_be[b]) mem_q[{wr_ptr_q, wr_word}][8*b +: 8] <= wr_data[8*b +: 8];
            end
        end
    end

    // Flag host misuse in simulation; the offending access is dropped or clamped
    always_ff @(posedge clk_i) begin
        if (reset_n_i) begin
            if (packet_req && bus.packet_wvalid_i)
                assert (wr_legal) else $warning("misaligned host write dropped");
            if (!packet_req && (bus.packet_wvalid_i || bus.packet_send_i))
                assert (1'b0) else $warning("host access while packet_req_o low ignored");
            if (packet_req && bus.packet_wsize_valid_i)
                assert (bus.packet_wsize_i <= packet_size_width_lp'(eth_mtu_p))
                else $warning("packet size clamped to MTU");
        end
    end

    assign bus.packet_req_o     = packet_req;
    assign bus.tx_axis_tdata_o  = tdata_q;
    assign bus.tx_axis_tkeep_o  = tkeep_q;
    assign bus.tx_axis_tvalid_o = tvalid_q;
    assign bus.tx_axis_tlast_o  = tlast_q;
    assign bus.tx_axis_tuser_o  = 1'b0;
    assign bus.send_count_o     = count_q;
endmodule
